// File: rtl/meter_peak_hold.sv
// meter_peak_hold: per-channel peak-magnitude meter with periodic sweep.
// Every HOLD_FRAMES frame strobes, all channels are walked once. Each channel's
// peak is written to the metering buffer, then decayed by peak >> DECAY_SHIFT.
// Optional feature macro: METER_CLIP_DETECT_EN adds the sticky full-scale flag
// clip_any. When the macro is undefined, clip_any is tied to 0.
module meter_peak_hold #(
    parameter int IO_WIDTH         = 24,
    parameter int METER_ADDR_WIDTH = 8,
    parameter int DECAY_SHIFT      = 4,
    parameter int HOLD_FRAMES      = 1024
) (
    input  logic                        dsp_clk,
    input  logic                        reset_n,
    input  logic [IO_WIDTH-1:0]         meter_in_data,
    input  logic [METER_ADDR_WIDTH-1:0] meter_in_addr,
    input  logic                        meter_in_en,
    input  logic                        frame_strobe,
    output logic [IO_WIDTH-1:0]         meter_wr_data,
    output logic [7:0]                  meter_wr_addr,
    output logic                        meter_wr_en,
    output logic                        sweep_busy,
    output logic                        clip_any
);

    localparam int N    = 2 ** METER_ADDR_WIDTH;
    localparam int FC_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

    localparam logic [IO_WIDTH-1:0]         MAG_MAX  = {1'b0, {(IO_WIDTH-1){1'b1}}};
    localparam logic [IO_WIDTH-1:0]         MOST_NEG = {1'b1, {(IO_WIDTH-1){1'b0}}};
    localparam logic [FC_W-1:0]             FC_LAST  = FC_W'(HOLD_FRAMES - 1);
    localparam logic [METER_ADDR_WIDTH-1:0] IDX_LAST = '1;

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t                        state_q, state_d;
    logic [METER_ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic [FC_W-1:0]               fcnt_q, fcnt_d;
    logic [IO_WIDTH-1:0]           peak_q [N];
    logic [IO_WIDTH-1:0]           peak_d [N];
    logic [IO_WIDTH-1:0]           wr_data_q, wr_data_d;
    logic [7:0]                    wr_addr_q, wr_addr_d;
    logic                          wr_en_q, wr_en_d;
    logic                          sweep_busy_q, sweep_busy_d;

    logic [IO_WIDTH-1:0]           mag;
    logic [IO_WIDTH-1:0]           cur;
    logic [IO_WIDTH-1:0]           decayed;
    logic                          hit_sweep;
    logic                          wrap;

    // Magnitude of the signed input; the most-negative code saturates to full scale.
    always_comb begin
        mag = meter_in_data;
        if (meter_in_data[IO_WIDTH-1])
            mag = (meter_in_data == MOST_NEG) ? MAG_MAX : -meter_in_data;
    end

    // Next state: frame counter, peak capture, and sweep walk with decay.
    always_comb begin
        peak_d       = peak_q;
        state_d      = state_q;
        idx_d        = idx_q;
        fcnt_d       = fcnt_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;

        cur       = peak_q[idx_q];
        decayed   = cur - (cur >> DECAY_SHIFT);
        hit_sweep = (state_q == SWEEP) && meter_in_en && (meter_in_addr == idx_q);
        wrap      = frame_strobe && (fcnt_q == FC_LAST);

        // The strobe keeps counting during a sweep; a wrap there is simply absorbed.
        if (frame_strobe)
            fcnt_d = wrap ? '0 : fcnt_q + 1'b1;

        // A plain max-update. The sweep branch below overrides the swept channel.
        // It folds the incoming magnitude into the decayed value, so a
        // coincident sample is never lost.
        if (meter_in_en && (mag > peak_q[meter_in_addr]))
            peak_d[meter_in_addr] = mag;

        if (state_q == SWEEP) begin
            wr_en_d       = 1'b1;
            wr_addr_d     = 8'(idx_q);
            wr_data_d     = (hit_sweep && (mag > cur)) ? mag : cur;
            peak_d[idx_q] = (hit_sweep && (mag > decayed)) ? mag : decayed;
            if (idx_q == IDX_LAST)
                state_d = IDLE;
            else
                idx_d = idx_q + 1'b1;
        end else if (wrap) begin
            state_d = SWEEP;
            idx_d   = '0;
        end

        sweep_busy_d = (state_d == SWEEP);
    end

    // State, peak storage and registered buffer-write outputs.
    always_ff @(posedge dsp_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            fcnt_q       <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            sweep_busy_q <= 1'b0;
            for (int i = 0; i < N; i++)
                peak_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            fcnt_q       <= fcnt_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            sweep_busy_q <= sweep_busy_d;
            peak_q       <= peak_d;
        end
    end

    assign meter_wr_en   = wr_en_q;
    assign meter_wr_addr = wr_addr_q;
    assign meter_wr_data = wr_data_q;
    assign sweep_busy    = sweep_busy_q;

`ifdef METER_CLIP_DETECT_EN
    logic clip_q, clip_d;
    logic clip_set, sweep_end;

    // Sticky clip flag.
    // Setting takes priority over the clear at the last sweep cycle.
    always_comb begin
        clip_set  = meter_in_en && (mag == MAG_MAX);
        sweep_end = (state_q == SWEEP) && (idx_q == IDX_LAST);
        clip_d    = clip_q;
        if (clip_set)
            clip_d = 1'b1;
        else if (sweep_end)
            clip_d = 1'b0;
    end

    // Clip flag register.
    always_ff @(posedge dsp_clk or negedge reset_n) begin
        if (!reset_n)
            clip_q <= 1'b0;
        else
            clip_q <= clip_d;
    end

    assign clip_any = clip_q;
`else
    assign clip_any = 1'b0;
`endif

endmodule

// File: tb/tb_meter_peak_hold.sv
// Bench for meter_peak_hold: directed scenarios plus randomized traffic.
// Results are checked against a per-channel behavioural reference model.
module tb_meter_peak_hold;

    localparam int IOW = 24;
    localparam int AW  = 8;
    localparam int DS  = 4;
    localparam int HF  = 4;
    localparam int NCH = 256;
`ifdef METER_CLIP_DETECT_EN
    localparam bit CLIP_ON = 1'b1;
`else
    localparam bit CLIP_ON = 1'b0;
`endif

    logic            dsp_clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [IOW-1:0]  meter_in_data = '0;
    logic [AW-1:0]   meter_in_addr = '0;
    logic            meter_in_en = 1'b0;
    logic            frame_strobe = 1'b0;
    logic [IOW-1:0]  meter_wr_data;
    logic [7:0]      meter_wr_addr;
    logic            meter_wr_en;
    logic            sweep_busy;
    logic            clip_any;

    int total = 0;
    int bad   = 0;

    meter_peak_hold #(
        .IO_WIDTH(IOW), .METER_ADDR_WIDTH(AW), .DECAY_SHIFT(DS), .HOLD_FRAMES(HF)
    ) dut (
        .dsp_clk(dsp_clk), .reset_n(reset_n),
        .meter_in_data(meter_in_data), .meter_in_addr(meter_in_addr),
        .meter_in_en(meter_in_en), .frame_strobe(frame_strobe),
        .meter_wr_data(meter_wr_data), .meter_wr_addr(meter_wr_addr),
        .meter_wr_en(meter_wr_en), .sweep_busy(sweep_busy), .clip_any(clip_any)
    );

    always #5 dsp_clk = ~dsp_clk;

    typedef struct {int cyc; int addr; int data;} wr_t;
    wr_t dq[$];   // writes seen at the DUT
    wr_t mq[$];   // writes predicted by the model

    // ---------------- reference model ----------------
    int mpk [NCH];
    int mcnt, midx;
    int mcyc = 0;
    bit msw, e_busy, e_clip;

    function automatic int mag(input logic [IOW-1:0] d);
        int v;
        v = int'($signed(d));
        if (v == -(2 ** (IOW-1))) return 2 ** (IOW-1) - 1;
        return (v < 0) ? -v : v;
    endfunction

    always @(posedge dsp_clk) mcyc <= mcyc + 1;

    always @(posedge dsp_clk or negedge reset_n) begin
        int m, cur, nv;
        bit hit, wrap;
        if (!reset_n) begin
            foreach (mpk[i]) mpk[i] <= 0;
            mcnt <= 0; midx <= 0; msw <= 0; e_busy <= 0; e_clip <= 0;
        end else begin
            m    = mag(meter_in_data);
            wrap = frame_strobe && (mcnt == HF - 1);
            hit  = msw && meter_in_en && (int'(meter_in_addr) == midx);
            if (frame_strobe) mcnt <= wrap ? 0 : mcnt + 1;
            if (meter_in_en && !hit && m > mpk[meter_in_addr]) mpk[meter_in_addr] <= m;
            if (msw) begin
                cur = mpk[midx];
                mq.push_back('{mcyc + 1, midx, (hit && m > cur) ? m : cur});
                nv = cur - cur / (2 ** DS);
                mpk[midx] <= (hit && m > nv) ? m : nv;
                if (midx == NCH - 1) msw <= 0;
                else midx <= midx + 1;
                e_busy <= (midx != NCH - 1);
            end else begin
                if (wrap) begin msw <= 1; midx <= 0; end
                e_busy <= wrap;
            end
            if (CLIP_ON && meter_in_en && m == 2 ** (IOW-1) - 1) e_clip <= 1;
            else if (msw && midx == NCH - 1) e_clip <= 0;
        end
    end

    // Capture DUT buffer writes, stamped with the cycle they appear in.
    always @(negedge dsp_clk)
        if (meter_wr_en) dq.push_back('{mcyc, int'(meter_wr_addr), int'(meter_wr_data)});

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic drive(input bit en, input int addr, input logic [IOW-1:0] d, input bit stb);
        meter_in_en = en; meter_in_addr = 8'(addr); meter_in_data = d; frame_strobe = stb;
        @(negedge dsp_clk);
        meter_in_en = 1'b0; frame_strobe = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, '0, 0);
    endtask

    task automatic strobes(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, '0, 1);
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        @(negedge dsp_clk); @(negedge dsp_clk);
        reset_n = 1'b1;
        @(negedge dsp_clk);
        dq.delete(); mq.delete();
    endtask

    function automatic int find_wr(input int addr, input int nth);
        int k = 0;
        foreach (dq[i]) if (dq[i].addr == addr) begin
            if (k == nth) return dq[i].data;
            k++;
        end
        return -1;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        drive(1, 3, 24'h7FFFFF, 1);
        drive(1, 4, 24'h800000, 1);
        strobes(4);
        total++; if (meter_wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en: got %b want 0", meter_wr_en); end
        total++; if (meter_wr_addr !== 8'h00) begin bad++; $display("FAIL reset_wr_addr: got %h want 00", meter_wr_addr); end
        total++; if (meter_wr_data !== 24'h0) begin bad++; $display("FAIL reset_wr_data: got %h want 0", meter_wr_data); end
        total++; if (sweep_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", sweep_busy); end
        total++; if (clip_any !== 1'b0) begin bad++; $display("FAIL reset_clip: got %b want 0", clip_any); end
        reset_n = 1'b1;
        @(negedge dsp_clk);
    endtask

    task automatic test_peak_ch3();
        int d;
        apply_reset();
        drive(1, 3, 24'h000100, 0);
        drive(1, 3, 24'hFFF000, 0);
        drive(1, 3, 24'h000200, 0);
        strobes(4);
        idle(NCH + 2);
        d = find_wr(3, 0);
        total++; if (d !== 32'h1000) begin bad++; $display("FAIL ch3_peak: got %h want 001000", d); end
        total++; if (dq.size() !== NCH) begin bad++; $display("FAIL ch3_write_count: got %0d want %0d", dq.size(), NCH); end
        total++; if (dq.size() !== mq.size()) begin bad++; $display("FAIL ch3_model_count: got %0d want %0d", dq.size(), mq.size()); end
        else foreach (dq[i]) begin
            total++;
            if (dq[i] != mq[i]) begin
                bad++;
                $display("FAIL ch3_sweep_entry %0d: got c%0d a%0d d%h want c%0d a%0d d%h",
                         i, dq[i].cyc, dq[i].addr, dq[i].data, mq[i].cyc, mq[i].addr, mq[i].data);
            end
        end
    endtask

    task automatic test_sweep_timing();
        bit order_ok;
        apply_reset();
        strobes(3);
        idle(5);
        total++; if (sweep_busy !== 1'b0) begin bad++; $display("FAIL busy_early: got %b want 0", sweep_busy); end
        total++; if (dq.size() !== 0) begin bad++; $display("FAIL writes_early: got %0d want 0", dq.size()); end
        strobes(1);
        total++; if (sweep_busy !== 1'b1) begin bad++; $display("FAIL busy_rise: got %b want 1", sweep_busy); end
        total++; if (meter_wr_en !== 1'b0) begin bad++; $display("FAIL wr_en_latency: got %b want 0", meter_wr_en); end
        idle(1);
        total++; if (meter_wr_en !== 1'b1 || meter_wr_addr !== 8'd0) begin bad++; $display("FAIL first_write: got en%b a%0d want en1 a0", meter_wr_en, meter_wr_addr); end
        idle(9);
        strobes(4);  // wraps the frame counter mid-sweep
        idle(NCH - 14);
        total++; if (meter_wr_en !== 1'b1 || meter_wr_addr !== 8'd255) begin bad++; $display("FAIL last_write: got en%b a%0d want en1 a255", meter_wr_en, meter_wr_addr); end
        total++; if (sweep_busy !== 1'b0) begin bad++; $display("FAIL busy_fall: got %b want 0", sweep_busy); end
        idle(1);
        total++; if (meter_wr_en !== 1'b0) begin bad++; $display("FAIL wr_en_after: got %b want 0", meter_wr_en); end
        idle(40);
        order_ok = (dq.size() == NCH);
        foreach (dq[i]) if (dq[i].addr != i || dq[i].cyc != dq[0].cyc + i) order_ok = 0;
        total++; if (order_ok !== 1'b1) begin bad++; $display("FAIL sweep_order: got %0d writes ordered=%b want %0d ordered=1", dq.size(), order_ok, NCH); end
        strobes(3);
        idle(3);
        total++; if (sweep_busy !== 1'b0 || dq.size() !== NCH) begin bad++; $display("FAIL no_restart: got busy%b n%0d want busy0 n%0d", sweep_busy, dq.size(), NCH); end
        strobes(1);
        total++; if (sweep_busy !== 1'b1) begin bad++; $display("FAIL second_sweep: got %b want 1", sweep_busy); end
        idle(NCH + 2);
    endtask

    task automatic test_decay();
        int d0, d1;
        apply_reset();
        drive(1, 0, 24'h010000, 0);
        strobes(4); idle(NCH + 2);
        strobes(4); idle(NCH + 2);
        d0 = find_wr(0, 0);
        d1 = find_wr(0, 1);
        total++; if (d0 !== 32'h10000) begin bad++; $display("FAIL decay_first: got %h want 010000", d0); end
        total++; if (d1 !== 32'hF000) begin bad++; $display("FAIL decay_second: got %h want 00F000", d1); end
    endtask

    task automatic test_small_decay();
        int d1;
        apply_reset();
        drive(1, 12, 24'h00000F, 0);
        strobes(4); idle(NCH + 2);
        strobes(4); idle(NCH + 2);
        d1 = find_wr(12, 1);
        total++; if (d1 !== 32'hF) begin bad++; $display("FAIL small_decay: got %h want 00000F", d1); end
    endtask

    task automatic test_clip();
        int d;
        apply_reset();
        drive(1, 7, 24'h800000, 0);
        total++; if (clip_any !== CLIP_ON) begin bad++; $display("FAIL clip_set: got %b want %b", clip_any, CLIP_ON); end
        strobes(4);
        idle(50);
        total++; if (clip_any !== CLIP_ON) begin bad++; $display("FAIL clip_hold: got %b want %b", clip_any, CLIP_ON); end
        idle(NCH);
        total++; if (clip_any !== 1'b0) begin bad++; $display("FAIL clip_clear: got %b want 0", clip_any); end
        d = find_wr(7, 0);
        total++; if (d !== 32'h7FFFFF) begin bad++; $display("FAIL clip_value: got %h want 7FFFFF", d); end
    endtask

    task automatic test_collision();
        int d0, d1;
        apply_reset();
        drive(1, 5, 24'h000100, 0);
        strobes(4);
        idle(5);
        drive(1, 5, 24'h020000, 0);
        idle(NCH);
        strobes(4); idle(NCH + 2);
        d0 = find_wr(5, 0);
        d1 = find_wr(5, 1);
        total++; if (d0 !== 32'h20000) begin bad++; $display("FAIL collide_out: got %h want 020000", d0); end
        total++; if (d1 !== 32'h20000) begin bad++; $display("FAIL collide_store: got %h want 020000", d1); end
    endtask

    task automatic test_back_to_back();
        int d;
        apply_reset();
        drive(1, 9, 24'h000300, 0);
        drive(1, 9, 24'h000500, 0);
        drive(1, 9, 24'h000400, 0);
        drive(1, 9, 24'hFFFA00, 0);
        drive(1, 9, 24'h000100, 0);
        strobes(4); idle(NCH + 2);
        d = find_wr(9, 0);
        total++; if (d !== 32'h600) begin bad++; $display("FAIL back_to_back: got %h want 000600", d); end
    endtask

    task automatic test_reset_mid_sweep();
        apply_reset();
        drive(1, 1, 24'h123456, 0);
        strobes(4);
        idle(100);
        total++; if (meter_wr_en !== 1'b1 || meter_wr_addr !== 8'd99) begin bad++; $display("FAIL pre_abort: got en%b a%0d want en1 a99", meter_wr_en, meter_wr_addr); end
        #2 reset_n = 1'b0;
        #1;
        total++; if ({meter_wr_en, sweep_busy, clip_any} !== 3'b000 || meter_wr_addr !== 8'h0 || meter_wr_data !== 24'h0) begin
            bad++; $display("FAIL abort_outputs: got en%b busy%b clip%b a%h d%h want all 0", meter_wr_en, sweep_busy, clip_any, meter_wr_addr, meter_wr_data);
        end
        @(negedge dsp_clk);
        reset_n = 1'b1;
        dq.delete(); mq.delete();
        idle(1);
        strobes(3);
        idle(20);
        total++; if (dq.size() !== 0 || sweep_busy !== 1'b0) begin bad++; $display("FAIL post_abort_quiet: got n%0d busy%b want n0 busy0", dq.size(), sweep_busy); end
        strobes(1);
        total++; if (sweep_busy !== 1'b1) begin bad++; $display("FAIL post_abort_sweep: got %b want 1", sweep_busy); end
        idle(NCH + 2);
        total++; if (find_wr(1, 0) !== 0) begin bad++; $display("FAIL post_abort_peak: got %h want 0", find_wr(1, 0)); end
    endtask

    task automatic test_random();
        int a;
        logic [IOW-1:0] d;
        apply_reset();
        for (int it = 0; it < 3000; it++) begin
            case ($urandom_range(0, 5))
                0: d = 24'h800000;
                1: d = 24'h7FFFFF;
                2: d = 24'($urandom_range(0, 31));
                3: d = -24'($urandom_range(1, 40));
                default: d = 24'($urandom);
            endcase
            a = (msw && $urandom_range(0, 2) == 0) ? midx : $urandom_range(0, NCH - 1);
            drive($urandom_range(0, 9) < 7, a, d, $urandom_range(0, 5) == 0);
            total++; if (sweep_busy !== e_busy) begin bad++; $display("FAIL rand_busy it%0d: got %b want %b", it, sweep_busy, e_busy); end
            total++; if (clip_any !== e_clip) begin bad++; $display("FAIL rand_clip it%0d: got %b want %b", it, clip_any, e_clip); end
        end
        idle(NCH + 5);
        total++; if (dq.size() !== mq.size()) begin bad++; $display("FAIL rand_count: got %0d want %0d", dq.size(), mq.size()); end
        else foreach (dq[i]) begin
            total++;
            if (dq[i] != mq[i]) begin
                bad++;
                $display("FAIL rand_entry %0d: got c%0d a%0d d%h want c%0d a%0d d%h",
                         i, dq[i].cyc, dq[i].addr, dq[i].data, mq[i].cyc, mq[i].addr, mq[i].data);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_peak_ch3();
        test_sweep_timing();
        test_decay();
        test_small_decay();
        test_clip();
        test_collision();
        test_back_to_back();
        test_reset_mid_sweep();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/meter_peak_hold.md
METER_PEAK_HOLD -- requirements
Module: meter_peak_hold

Interface
REQ-001 SHALL have parameter IO_WIDTH, default 24, meter sample width in bits (two's complement).
REQ-002 SHALL have parameter METER_ADDR_WIDTH, default 8, channel index width; channel count N = 2^METER_ADDR_WIDTH.
REQ-003 SHALL have parameter DECAY_SHIFT, default 4, decay applied per sweep: peak - (peak >> DECAY_SHIFT).
REQ-004 SHALL have parameter HOLD_FRAMES, default 1024, number of frame_strobe pulses between sweeps (>= 1).
REQ-005 SHALL have port dsp_clk  input  1  sole clock, all logic rising-edge.
REQ-006 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port meter_in_data  input  IO_WIDTH  signed sample from the DSP core meter tap.
REQ-008 SHALL have port meter_in_addr  input  METER_ADDR_WIDTH  channel index of meter_in_data.
REQ-009 SHALL have port meter_in_en  input  1  qualifies meter_in_data/addr for one cycle.
REQ-010 SHALL have port frame_strobe  input  1  one-cycle pulse per sample frame (program counter wrap).
REQ-011 SHALL have port meter_wr_data  output  IO_WIDTH  peak magnitude to metering buffer.
REQ-012 SHALL have port meter_wr_addr  output  8  metering buffer address (channel index, zero-extended).
REQ-013 SHALL have port meter_wr_en  output  1  metering buffer write enable.
REQ-014 SHALL have port sweep_busy  output  1  high while in SWEEP state.
REQ-015 SHALL have port clip_any  output  1  sticky full-scale indicator (see Configuration).

Function
REQ-016 SHALL compute magnitude of meter_in_data: negatives negated; most-negative value saturates to 2^(IO_WIDTH-1)-1.
REQ-017 SHALL hold a peak register per channel; when meter_in_en, peak[addr] <= max(peak[addr], magnitude) at the next edge.
REQ-018 SHALL update correctly for back-to-back meter_in_en to the same channel on consecutive cycles (no lost maximum).
REQ-019 SHALL keep frame counter 0..HOLD_FRAMES-1; increment on frame_strobe, wrap to 0 on strobe at HOLD_FRAMES-1.
REQ-020 SHALL implement states IDLE and SWEEP; IDLE->SWEEP on the edge where the counter wraps, with index = 0.
REQ-021 SHALL, in SWEEP at index k, register meter_wr_en=1, meter_wr_addr=k, meter_wr_data=peak[k] at the next edge (one-cycle latency).
REQ-022 SHALL, in SWEEP at index k, write peak[k] <= peak[k] - (peak[k] >> DECAY_SHIFT) at the same edge.
REQ-023 SHALL, when meter_in_en targets channel k during the sweep cycle for k, output max(peak[k], magnitude) and store max(decayed value, magnitude).
REQ-024 SHALL increment index each SWEEP cycle and return to IDLE after index N-1; a sweep lasts exactly N cycles.
REQ-025 SHALL count frame_strobe during SWEEP; a counter wrap during SWEEP SHALL not start or restart a sweep.
REQ-026 SHALL drive meter_wr_en=0 in every cycle not following a SWEEP cycle.
REQ-027 SHALL decay a nonzero peak smaller than 2^DECAY_SHIFT to itself (shift result 0); no underflow below 0.

Reset
REQ-028 SHALL, on reset_n low, asynchronously clear all peaks, frame counter, index, state (IDLE), meter_wr_data/addr/en, sweep_busy, clip_any.
REQ-029 SHALL abort a sweep in progress on reset; the first sweep after release occurs after HOLD_FRAMES strobes.

Configuration
REQ-030 SHALL, with METER_CLIP_DETECT_EN defined, set clip_any when magnitude = 2^(IO_WIDTH-1)-1 on any meter_in_en, and clear it on the edge that ends a sweep unless set in that same cycle.
REQ-031 SHALL, without METER_CLIP_DETECT_EN, keep clip_any constant 0 and contain no clip logic.

Verification
REQ-032 SHALL test: write ch3 values 0x000100, 0xFFF000, 0x000200 -> peak[3] = 0x001000; ch3 emitted 0x001000 in next sweep.
REQ-033 SHALL test: HOLD_FRAMES=4, 4 strobes -> sweep_busy rises on the edge after the 4th strobe, 256 writes addr 0..255, then IDLE.
REQ-034 SHALL test: peak[0]=0x010000, DECAY_SHIFT=4, two sweeps -> emitted 0x010000 then 0x00F000.
REQ-035 SHALL test: meter_in_data=0x800000 -> stored 0x7FFFFF; with METER_CLIP_DETECT_EN clip_any=1 until sweep end.
REQ-036 SHALL test: meter_in_en to ch5 with 0x020000 in the sweep cycle for ch5 (peak 0x000100) -> output 0x020000, stored 0x020000.
REQ-037 SHALL test: reset_n low at sweep index 100 -> all outputs 0 immediately, no writes until HOLD_FRAMES strobes after release.
